// File: rtl/toy_boot_memory_if.sv
// ---------------------------------------------------------------------------
// toy_boot_memory_if
// Processor memory bus between the toy processor (master) and the boot
// memory (slave).
//   addr   : processor memory address
//   d_out  : processor write data
//   rw     : 1 = read, 0 = write, qualified by mem_en
//   mem_en : bus access strobe
//   d_in   : registered read data returned to the processor
// ---------------------------------------------------------------------------
interface toy_boot_memory_if;
  logic [7:0] addr;
  logic [7:0] d_out;
  logic       rw;
  logic       mem_en;
  logic [7:0] d_in;

  modport master (
    output addr,
    output d_out,
    output rw,
    output mem_en,
    input  d_in
  );

  modport slave (
    input  addr,
    input  d_out,
    input  rw,
    input  mem_en,
    output d_in
  );
endinterface

// File: rtl/toy_boot_memory.sv
// ---------------------------------------------------------------------------
// toy_boot_memory
// Unified 256x8 program/data memory with a boot loader. After reset a program
// is streamed in over a valid/ready byte interface while the processor is held
// in reset. After the last byte and a short hold, the processor is released
// and the memory serves its bus.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-high reset
//   bus          processor bus (slave modport): addr, d_out, rw, mem_en, d_in
//   i_ld_valid   loader byte valid
//   i_ld_data    loader byte
//   i_ld_last    final loader byte marker, sampled with i_ld_valid
//   o_ld_ready   loader byte accepted when i_ld_valid && o_ld_ready
//   o_cpu_reset  processor reset, high during LOAD and HOLD
//   o_boot_done  high in RUN
//   o_wp_err     one-cycle pulse on a dropped protected write
//
// Build option:
//   MEM_WRITE_PROTECT_EN  when defined, processor writes below PROTECT_TOP are
//                         dropped and flagged on o_wp_err. When undefined all
//                         writes are performed and o_wp_err stays 0.
// ---------------------------------------------------------------------------
module toy_boot_memory #(
  parameter logic [7:0]  LOAD_BASE   = 8'h00,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [7:0]  PROTECT_TOP = 8'h80
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  toy_boot_memory_if.slave         bus,
  input  logic                     i_ld_valid,
  input  logic [7:0]               i_ld_data,
  input  logic                     i_ld_last,
  output logic                     o_ld_ready,
  output logic                     o_cpu_reset,
  output logic                     o_boot_done,
  output logic                     o_wp_err
);

  // state  | meaning
  // S_LOAD | accept loader bytes into mem[ptr], processor held in reset
  // S_HOLD | count HOLD_CYCLES with processor still in reset
  // S_RUN  | processor released, bus reads/writes served

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_ptr;
  logic [3:0] r_hold_cnt;
  logic       r_ld_ready;
  logic       r_cpu_reset;
  logic       r_boot_done;
  logic       r_wp_err;
  logic [7:0] r_d_in;
  logic [7:0] r_mem [256];

  logic       w_ld_accept;
  logic [7:0] w_ptr_next;
  logic       w_bus_wr;
  logic       w_bus_rd;
  logic       w_wp_hit;
  logic       w_mem_we;
  logic [7:0] w_mem_addr;
  logic [7:0] w_mem_wdata;

  // r_ld_ready is only ever set while in LOAD; the state term keeps the
  // accept strictly tied to LOAD regardless.
  assign w_ld_accept = (r_state == S_LOAD) && r_ld_ready && i_ld_valid && !i_reset;
  assign w_ptr_next  = r_ptr + 8'd1;
  assign w_bus_wr    = (r_state == S_RUN) && bus.mem_en && !bus.rw && !i_reset;
  assign w_bus_rd    = (r_state == S_RUN) && bus.mem_en &&  bus.rw;

`ifdef MEM_WRITE_PROTECT_EN
  assign w_wp_hit = w_bus_wr && (bus.addr < PROTECT_TOP);
`else
  assign w_wp_hit = 1'b0;
`endif

  // Loader and processor never write in the same state, so a simple mux on
  // the accept is enough to share the single write port.
  assign w_mem_we    = w_ld_accept || (w_bus_wr && !w_wp_hit);
  assign w_mem_addr  = w_ld_accept ? r_ptr     : bus.addr;
  assign w_mem_wdata = w_ld_accept ? i_ld_data : bus.d_out;

  // Contents survive reset; a re-load only overwrites what it writes.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_LOAD;
      r_ptr       <= LOAD_BASE;
      r_hold_cnt  <= 4'd0;
      r_ld_ready  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_boot_done <= 1'b0;
      r_wp_err    <= 1'b0;
      r_d_in      <= 8'h00;
    end else begin
      r_wp_err <= w_wp_hit;
      case (r_state)
        S_LOAD: begin
          r_ld_ready  <= 1'b1;
          r_cpu_reset <= 1'b1;
          r_boot_done <= 1'b0;
          if (w_ld_accept) begin
            r_ptr <= w_ptr_next;
            // Wrapping back to LOAD_BASE means this was the 256th byte.
            if (i_ld_last || (w_ptr_next == LOAD_BASE)) begin
              r_state    <= S_HOLD;
              r_ld_ready <= 1'b0;
              r_hold_cnt <= 4'(HOLD_CYCLES);
            end
          end
        end
        S_HOLD: begin
          r_ld_ready <= 1'b0;
          if (r_hold_cnt <= 4'd1) begin
            r_state     <= S_RUN;
            r_cpu_reset <= 1'b0;
            r_boot_done <= 1'b1;
            r_hold_cnt  <= 4'd0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end
        end
        S_RUN: begin
          r_ld_ready  <= 1'b0;
          r_cpu_reset <= 1'b0;
          r_boot_done <= 1'b1;
          if (w_bus_rd) begin
            r_d_in <= r_mem[bus.addr];
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign o_ld_ready  = r_ld_ready;
  assign o_cpu_reset = r_cpu_reset;
  assign o_boot_done = r_boot_done;
  assign o_wp_err    = r_wp_err;
  assign bus.d_in    = r_d_in;

endmodule

// File: doc/toy_boot_memory.md
# toy_boot_memory

Unified 256×8 program/data memory that sits directly downstream of the toy processor's memory bus (ADDR, D_OUT, RW, MEM_EN) and returns read data on D_IN. After reset it runs a boot-load phase: it accepts a program as a valid/ready byte stream into consecutive memory locations while holding the processor in reset via CPU_RESET. Once loading completes it releases the processor and serves bus reads and writes.

## Interface
Parameters:
- LOAD_BASE, 8'h00, first address written by the boot loader.
- HOLD_CYCLES, 2, cycles CPU_RESET stays high after the last load byte (range 1–15).
- PROTECT_TOP, 8'h80, with write protection compiled in, processor writes to addresses below this value are dropped.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDR  in  8  processor memory address.
- D_OUT  in  8  processor write data.
- RW  in  1  1 = read, 0 = write; qualified by MEM_EN.
- MEM_EN  in  1  processor bus access strobe.
- D_IN  out  8  registered read data to the processor.
- LD_VALID  in  1  loader byte valid.
- LD_DATA  in  8  loader byte.
- LD_LAST  in  1  marks the final byte; sampled with LD_VALID.
- LD_READY  out  1  loader byte accepted when LD_VALID && LD_READY.
- CPU_RESET  out  1  reset to processor; high during LOAD and HOLD.
- BOOT_DONE  out  1  high in RUN.
- WP_ERR  out  1  one-cycle pulse on a dropped protected write.

## Operation
- FSM states: LOAD → HOLD → RUN. RESET forces LOAD from any state, including mid-load and RUN.
- LOAD:
  - LD_READY = 1.
  - On each accepted byte, mem[ptr] ← LD_DATA, then ptr ← ptr+1 with 8-bit wrap.
  - Leave LOAD to HOLD when the accepted byte has LD_LAST = 1, or when the accepted byte is the 256th since entry (ptr returns to LOAD_BASE). The 256th byte is written; no overwrite beyond it.
  - Processor bus is ignored: no writes, D_IN holds.
- HOLD:
  - LD_READY = 0; CPU_RESET = 1.
  - Counter runs HOLD_CYCLES cycles, then the FSM moves to RUN.
- RUN:
  - LD_READY = 0, CPU_RESET = 0, BOOT_DONE = 1. LD_* inputs are ignored.
  - MEM_EN && !RW: mem[ADDR] ← D_OUT.
  - MEM_EN && RW: D_IN ← mem[ADDR].
  - !MEM_EN: memory unchanged, D_IN holds its value.
- Memory contents are not cleared by RESET. A re-load overwrites only the locations it writes.

## Timing
- Reset values, in the cycle after RESET is sampled high: state LOAD, ptr = LOAD_BASE, D_IN = 8'h00, LD_READY = 0, CPU_RESET = 1, BOOT_DONE = 0, WP_ERR = 0, HOLD counter = 0.
- LD_READY is a registered output. It rises in the first cycle after RESET deasserts. Bytes presented while RESET is high are not accepted.
- Load byte accepted at edge N is readable by the processor after boot.
- After the edge that accepts the last byte:
  - CPU_RESET stays 1 for exactly HOLD_CYCLES further cycles.
  - BOOT_DONE rises on the same edge that CPU_RESET falls.
- Read latency is 1 cycle: ADDR is sampled at edge N, and D_IN is valid after edge N until the next read.
- Write takes effect at the sampling edge. A read of the same address on the next cycle returns the new data.
- RESET asserted mid-load aborts the load: ptr returns to LOAD_BASE, and bytes already written remain in memory.

## Configuration
- MEM_WRITE_PROTECT_EN defined:
  - In RUN, a processor write (MEM_EN && !RW) with ADDR < PROTECT_TOP is dropped, and WP_ERR = 1 for the following cycle.
  - Loader writes are never protected.
- MEM_WRITE_PROTECT_EN undefined: all RUN writes are performed, and WP_ERR is constant 0.

## Test plan
- Reset, stream 4 bytes 8'h11, 8'h22, 8'h33, 8'h44 with LD_LAST on the last, LOAD_BASE = 0 -> CPU_RESET high 2 cycles after the 4th accept, then BOOT_DONE = 1; reads of addresses 0..3 return 11, 22, 33, 44 with 1-cycle latency.
- RUN write 8'hA5 to 8'hF0, then read 8'hF0 next cycle -> D_IN = 8'hA5. Hold MEM_EN low for 3 cycles -> D_IN stays 8'hA5.
- Stream 256 bytes with no LD_LAST, value = address XOR 8'hFF -> FSM enters HOLD after the 256th byte; LD_READY = 0 and a 257th byte is not accepted; address 8'h00 reads 8'hFF.
- Gap LD_VALID low for random cycles during load, and assert RESET after 2 of 5 bytes -> ptr restarts at LOAD_BASE; re-streamed bytes overwrite addresses 0..4, and BOOT_DONE stays 0 until the new LD_LAST plus HOLD_CYCLES.
- With MEM_WRITE_PROTECT_EN, write 8'h5A to 8'h10 in RUN -> mem[8'h10] unchanged and WP_ERR pulses 1 cycle. Write to 8'h90 -> performed with no WP_ERR. Without the macro, the write to 8'h10 is performed.
